// File: rtl/pal_cfg_loader.sv
// PAL configuration loader: accepts bitstream words over valid/ready and
// shifts them LSB first onto the PAL serial CFG input, one bit per cycle,
// stopping after exactly CFG_LEN bits and holding DONE until the next START.
module pal_cfg_loader #(
  parameter int N      = 4,
  parameter int M      = 3,
  parameter int P      = 3,
  parameter int WORD_W = 8
) (
  input  logic                                 CLK,
  input  logic                                 RST_N,
  input  logic                                 START,
  input  logic [WORD_W-1:0]                    WORD_DATA,
  input  logic                                 WORD_VALID,
  output logic                                 WORD_READY,
  output logic                                 CFG_BIT,
  output logic                                 CFG_SHIFT,
  output logic                                 BUSY,
  output logic                                 DONE,
  output logic [$clog2(2*N*P+M*P+1)-1:0]       BIT_CNT
);

  localparam int CFG_LEN = 2*N*P + M*P;
  localparam int CNT_W   = $clog2(CFG_LEN + 1);
  localparam int IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] CFG_LEN_C = CNT_W'(CFG_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              word_ready_q, word_ready_d;
  logic              cfg_bit_q, cfg_bit_d;
  logic              cfg_shift_q, cfg_shift_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state logic: START only matters when not loading; a word is taken
  // only on the handshake; SHIFT ends at the word boundary or at CFG_LEN.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d   = S_WAIT_WORD;
          bit_cnt_d = '0;
        end
      end
      S_WAIT_WORD: begin
        if (WORD_VALID && word_ready_q) begin
          shreg_d = WORD_DATA;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        idx_d     = idx_q + IDX_W'(1);
        if (bit_cnt_d == CFG_LEN_C) begin
          state_d = S_DONE;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_WAIT_WORD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop and
  // lines up with the cycle the state machine is actually in.
  always_comb begin
    word_ready_d = (state_d == S_WAIT_WORD);
    cfg_shift_d  = (state_d == S_SHIFT);
    busy_d       = word_ready_d || cfg_shift_d;
    done_d       = (state_d == S_DONE);
    cfg_bit_d    = cfg_shift_d ? shreg_d[idx_d] : 1'b0;
  end

  // State and output registers; reset abandons any partial load at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      bit_cnt_q    <= '0;
      word_ready_q <= 1'b0;
      cfg_bit_q    <= 1'b0;
      cfg_shift_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      bit_cnt_q    <= bit_cnt_d;
      word_ready_q <= word_ready_d;
      cfg_bit_q    <= cfg_bit_d;
      cfg_shift_q  <= cfg_shift_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign WORD_READY = word_ready_q;
  assign CFG_BIT    = cfg_bit_q;
  assign CFG_SHIFT  = cfg_shift_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign BIT_CNT    = bit_cnt_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader: directed test-plan loads plus
// randomized loads, checked against a word/bit-level timeline model.
module tb_pal_cfg_loader;

  localparam int N       = 4;
  localparam int M       = 3;
  localparam int P       = 3;
  localparam int WORD_W  = 8;
  localparam int CFG_LEN = 2*N*P + M*P;
  localparam int NWORDS  = (CFG_LEN + WORD_W - 1) / WORD_W;
  localparam int CNT_W   = $clog2(CFG_LEN + 1);

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic              START = 1'b0;
  logic [WORD_W-1:0] WORD_DATA = '0;
  logic              WORD_VALID = 1'b0;
  logic              WORD_READY;
  logic              CFG_BIT;
  logic              CFG_SHIFT;
  logic              BUSY;
  logic              DONE;
  logic [CNT_W-1:0]  BIT_CNT;

  int vectors = 0;
  int miscompares = 0;

  logic [WORD_W-1:0] cur_words [NWORDS];
  logic [63:0]       cap_bits;
  int                cap_cnt;
  logic [63:0]       first_stream;
  int                done_at;

  pal_cfg_loader #(.N(N), .M(M), .P(P), .WORD_W(WORD_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .WORD_DATA  (WORD_DATA),
    .WORD_VALID (WORD_VALID),
    .WORD_READY (WORD_READY),
    .CFG_BIT    (CFG_BIT),
    .CFG_SHIFT  (CFG_SHIFT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .BIT_CNT    (BIT_CNT)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  // Single comparison point for the whole bench
  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference stream: global bit k comes from word k/WORD_W, bit k%WORD_W
  function automatic logic [63:0] ref_stream();
    logic [63:0]       s;
    logic [WORD_W-1:0] w;
    s = '0;
    for (int k = 0; k < CFG_LEN; k++) begin
      w    = cur_words[k / WORD_W];
      s[k] = w[k % WORD_W];
    end
    return s;
  endfunction

  // Quiet-idle check: nothing shifts and DONE/BUSY stay low
  task automatic idle_check(input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (CFG_SHIFT !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    check_output("idle_quiet", bad, 0);
  endtask

  // One load from START; the model tracks "waiting for a word" versus
  // "shifting k bits of the current word" and the bench compares the DUT to
  // that timeline every cycle. Optional backpressure gap before a given
  // word, a stray START at a given cycle, reset after a number of shifted
  // bits, or random WORD_VALID drops.
  task automatic apply_stimulus(input int gap_word, input int gap_len, input int start_at,
                                input int abort_at, input bit rand_valid, output int done_n);
    int n, w, bits_done, bits_in_word, gap_cnt, tl_err;
    bit m_wait, m_done, v;
    n = 0; w = 0; bits_done = 0; bits_in_word = 0; gap_cnt = 0; tl_err = 0;
    m_wait = 1'b1; m_done = 1'b0;
    cap_bits = '0; cap_cnt = 0; done_n = -1;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 1;
    check_output("start_bitcnt", BIT_CNT, 0);
    while (n < 400) begin
      if (BUSY !== !m_done || WORD_READY !== (m_wait && !m_done) ||
          CFG_SHIFT !== (!m_wait && !m_done) || DONE !== m_done) tl_err++;
      if (CFG_SHIFT !== 1'b1 && CFG_BIT !== 1'b0) tl_err++;
      if (CFG_SHIFT === 1'b1) begin
        if (cap_cnt < 64) cap_bits[cap_cnt] = CFG_BIT;
        cap_cnt++;
      end
      if (DONE === 1'b1 && done_n < 0) done_n = n;
      if (m_done) break;
      if (abort_at > 0 && cap_cnt == abort_at) begin
        RST_N = 1'b0;
        #1;
        check_output("reset_outputs", {WORD_READY, CFG_BIT, CFG_SHIFT, BUSY, DONE, BIT_CNT}, 0);
        WORD_VALID = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        return;
      end
      START = (n == start_at);
      v = 1'b1;
      if (m_wait) begin
        if (w == gap_word && gap_cnt < gap_len) begin
          v = 1'b0;
          gap_cnt++;
        end else if (rand_valid && $urandom_range(0, 3) == 0) begin
          v = 1'b0;
        end
      end else if (rand_valid) begin
        v = ($urandom_range(0, 1) == 1);
      end
      WORD_VALID = v;
      WORD_DATA  = (m_wait && v) ? cur_words[w] : WORD_W'($urandom);
      if (m_wait) begin
        if (v) begin
          m_wait = 1'b0;
          bits_in_word = (CFG_LEN - bits_done < WORD_W) ? CFG_LEN - bits_done : WORD_W;
          w++;
        end
      end else begin
        bits_done++;
        bits_in_word--;
        if (bits_in_word == 0) begin
          if (bits_done == CFG_LEN) m_done = 1'b1;
          else m_wait = 1'b1;
        end
      end
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
    WORD_VALID = 1'b0;
    check_output("timeline", tl_err, 0);
    check_output("shift_count", cap_cnt, CFG_LEN);
    check_output("stream", cap_bits, ref_stream());
    check_output("bit_cnt_done", BIT_CNT, CFG_LEN);
  endtask

  // Safety net so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    #2 RST_N = 1'b0;
    #1;
    check_output("por_outputs", {WORD_READY, CFG_BIT, CFG_SHIFT, BUSY, DONE, BIT_CNT}, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    idle_check(20);

    cur_words[0] = 8'hA5; cur_words[1] = 8'h3C; cur_words[2] = 8'hFF;
    cur_words[3] = 8'h00; cur_words[4] = 8'h81;
    $display("[TB] full default load");
    apply_stimulus(-1, 0, 0, 0, 1'b0, done_at);
    check_output("full_done_at", done_at, 39);
    check_output("full_stream_literal", cap_bits, 64'h1_00FF_3CA5);
    first_stream = cap_bits;

    $display("[TB] backpressure before word 2");
    apply_stimulus(2, 5, 0, 0, 1'b0, done_at);
    check_output("bp_done_at", done_at, 44);
    check_output("bp_stream_same", cap_bits, first_stream);

    $display("[TB] START while shifting word 1");
    apply_stimulus(-1, 0, 14, 0, 1'b0, done_at);
    check_output("restart_ignored_done_at", done_at, 39);

    $display("[TB] reload while DONE");
    check_output("done_before_reload", DONE, 1);
    apply_stimulus(-1, 0, 0, 0, 1'b0, done_at);
    check_output("reload_stream_same", cap_bits, first_stream);

    $display("[TB] reset after 12 bits, then reload");
    apply_stimulus(-1, 0, 0, 12, 1'b0, done_at);
    idle_check(5);
    apply_stimulus(-1, 0, 0, 0, 1'b0, done_at);
    check_output("post_reset_stream", cap_bits, first_stream);
    check_output("post_reset_done_at", done_at, 39);

    $display("[TB] randomized loads");
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NWORDS; i++) cur_words[i] = WORD_W'($urandom);
      apply_stimulus(-1, 0, (r % 2 == 1) ? 20 : 0, 0, 1'b1, done_at);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
